s3g_link: RTL and testbench



---
 rtl/s3g_link.sv | 226 ++++++++++++++++++++++
 tb/tb_s3g_link.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/s3g_link.sv
// S3G byte-level packet link: RX parser with CRC-8/Maxim check and
// TX framer that serialises a short payload into an S3G packet.
module s3g_link #(
  parameter int MAX_PAYLOAD = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_done,
  output logic       rx_packet_valid,
  output logic       rx_crc_error,
  output logic [7:0] rx_len,
  output logic [7:0] rx_buf0,
  output logic [7:0] rx_buf1,
  output logic [7:0] rx_buf2,
  output logic [7:0] rx_buf3,
  input  logic [7:0] payload_len,
  input  logic [7:0] buf0,
  input  logic [7:0] buf1,
  input  logic [7:0] buf2,
  input  logic [7:0] buf3,
  input  logic       packet_wr,
  output logic [7:0] tx_data,
  output logic       tx_wr,
  input  logic       tx_done,
  output logic       tx_busy
);

  localparam logic [7:0] SYNC = 8'hD5;
  localparam int MAXC = (MAX_PAYLOAD > 255) ? 255 : MAX_PAYLOAD;
  localparam logic [7:0] MAX_L = 8'(MAXC);

  typedef enum logic [1:0] {
    RX_IDLE, RX_LEN, RX_PAY, RX_CRC
  } rx_st_e;

  typedef enum logic {
    TX_IDLE, TX_WAIT
  } tx_st_e;

  function automatic logic [7:0] crc8(
    input logic [7:0] c,
    input logic [7:0] b
  );
    logic [7:0] r;
    r = c ^ b;
    for (int i = 0; i < 8; i++) begin
      r = r[0] ? ((r >> 1) ^ 8'h8C) : (r >> 1);
    end
    return r;
  endfunction

  // ---------------- RX ----------------
  rx_st_e          rx_st_q, rx_st_d;
  logic [7:0]      rx_plen_q, rx_plen_d;
  logic [7:0]      rx_idx_q, rx_idx_d;
  logic [7:0]      rx_crc_q, rx_crc_d;
  logic [3:0][7:0] rx_stg_q, rx_stg_d;
  logic [3:0][7:0] rx_buf_q, rx_buf_d;
  logic [7:0]      rx_len_q, rx_len_d;
  logic            rx_vld_q, rx_vld_d;
  logic            rx_err_q, rx_err_d;

  always_comb begin
    rx_st_d   = rx_st_q;
    rx_plen_d = rx_plen_q;
    rx_idx_d  = rx_idx_q;
    rx_crc_d  = rx_crc_q;
    rx_stg_d  = rx_stg_q;
    rx_buf_d  = rx_buf_q;
    rx_len_d  = rx_len_q;
    rx_vld_d  = 1'b0;
    rx_err_d  = 1'b0;
    if (rx_done) begin
      unique case (rx_st_q)
        RX_IDLE: begin
          if (rx_data == SYNC) rx_st_d = RX_LEN;
        end
        RX_LEN: begin
          rx_plen_d = rx_data;
          rx_idx_d  = 8'd0;
          rx_crc_d  = 8'd0;
          rx_stg_d  = '0;
          if (rx_data > MAX_L)       rx_st_d = RX_IDLE;
          else if (rx_data == 8'd0)  rx_st_d = RX_CRC;
          else                       rx_st_d = RX_PAY;
        end
        RX_PAY: begin
          rx_crc_d = crc8(rx_crc_q, rx_data);
          if (rx_idx_q < 8'd4) rx_stg_d[rx_idx_q[1:0]] = rx_data;
          rx_idx_d = rx_idx_q + 8'd1;
          if (rx_idx_d == rx_plen_q) rx_st_d = RX_CRC;
        end
        RX_CRC: begin
          if (rx_data == rx_crc_q) begin
            rx_buf_d = rx_stg_q;
            rx_len_d = rx_plen_q;
            rx_vld_d = 1'b1;
          end else begin
            rx_err_d = 1'b1;
          end
          rx_st_d = RX_IDLE;
        end
        default: rx_st_d = RX_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_st_q   <= RX_IDLE;
      rx_plen_q <= '0;
      rx_idx_q  <= '0;
      rx_crc_q  <= '0;
      rx_stg_q  <= '0;
      rx_buf_q  <= '0;
      rx_len_q  <= '0;
      rx_vld_q  <= 1'b0;
      rx_err_q  <= 1'b0;
    end else begin
      rx_st_q   <= rx_st_d;
      rx_plen_q <= rx_plen_d;
      rx_idx_q  <= rx_idx_d;
      rx_crc_q  <= rx_crc_d;
      rx_stg_q  <= rx_stg_d;
      rx_buf_q  <= rx_buf_d;
      rx_len_q  <= rx_len_d;
      rx_vld_q  <= rx_vld_d;
      rx_err_q  <= rx_err_d;
    end
  end

  assign rx_packet_valid = rx_vld_q;
  assign rx_crc_error    = rx_err_q;
  assign rx_len          = rx_len_q;
  assign rx_buf0         = rx_buf_q[0];
  assign rx_buf1         = rx_buf_q[1];
  assign rx_buf2         = rx_buf_q[2];
  assign rx_buf3         = rx_buf_q[3];

  // ---------------- TX ----------------
  // cnt = index of the byte in flight: 0 sync, 1 len, 2..L+1 data, L+2 crc
  tx_st_e          tx_st_q, tx_st_d;
  logic [2:0]      tx_len_q, tx_len_d;
  logic [3:0][7:0] tx_pl_q, tx_pl_d;
  logic [2:0]      tx_cnt_q, tx_cnt_d;
  logic [7:0]      tx_crc_q, tx_crc_d;
  logic [7:0]      tx_data_q, tx_data_d;
  logic            tx_wr_q, tx_wr_d;
  logic            tx_busy_q, tx_busy_d;
  logic [2:0]      tx_pidx;

  always_comb begin
    tx_st_d   = tx_st_q;
    tx_len_d  = tx_len_q;
    tx_pl_d   = tx_pl_q;
    tx_cnt_d  = tx_cnt_q;
    tx_crc_d  = tx_crc_q;
    tx_data_d = tx_data_q;
    tx_wr_d   = 1'b0;
    tx_busy_d = tx_busy_q;
    tx_pidx   = 3'd0;
    unique case (tx_st_q)
      TX_IDLE: begin
        if (packet_wr) begin
          tx_len_d  = (payload_len > 8'd4) ? 3'd4 : payload_len[2:0];
          tx_pl_d   = {buf3, buf2, buf1, buf0};
          tx_cnt_d  = 3'd0;
          tx_crc_d  = 8'd0;
          tx_data_d = SYNC;
          tx_wr_d   = 1'b1;
          tx_busy_d = 1'b1;
          tx_st_d   = TX_WAIT;
        end
      end
      TX_WAIT: begin
        if (tx_done) begin
          if (tx_cnt_q == tx_len_q + 3'd2) begin
            tx_busy_d = 1'b0;
            tx_st_d   = TX_IDLE;
          end else begin
            tx_cnt_d = tx_cnt_q + 3'd1;
            tx_wr_d  = 1'b1;
            tx_pidx  = tx_cnt_d - 3'd2;
            if (tx_cnt_d == 3'd1) begin
              tx_data_d = {5'd0, tx_len_q};
            end else if (tx_cnt_d <= tx_len_q + 3'd1) begin
              tx_data_d = tx_pl_q[tx_pidx[1:0]];
              tx_crc_d  = crc8(tx_crc_q, tx_pl_q[tx_pidx[1:0]]);
            end else begin
              tx_data_d = tx_crc_q;
            end
          end
        end
      end
      default: tx_st_d = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_st_q   <= TX_IDLE;
      tx_len_q  <= '0;
      tx_pl_q   <= '0;
      tx_cnt_q  <= '0;
      tx_crc_q  <= '0;
      tx_data_q <= '0;
      tx_wr_q   <= 1'b0;
      tx_busy_q <= 1'b0;
    end else begin
      tx_st_q   <= tx_st_d;
      tx_len_q  <= tx_len_d;
      tx_pl_q   <= tx_pl_d;
      tx_cnt_q  <= tx_cnt_d;
      tx_crc_q  <= tx_crc_d;
      tx_data_q <= tx_data_d;
      tx_wr_q   <= tx_wr_d;
      tx_busy_q <= tx_busy_d;
    end
  end

  assign tx_data = tx_data_q;
  assign tx_wr   = tx_wr_q;
  assign tx_busy = tx_busy_q;

endmodule

// File: tb/tb_s3g_link.sv
// Directed bench for s3g_link: RX framing/CRC, TX framing and handshake,
// and mid-packet reset recovery.
module tb_s3g_link;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] rx_data;
  logic       rx_done;
  logic       rx_packet_valid;
  logic       rx_crc_error;
  logic [7:0] rx_len;
  logic [7:0] rx_buf0, rx_buf1, rx_buf2, rx_buf3;
  logic [7:0] payload_len;
  logic [7:0] buf0, buf1, buf2, buf3;
  logic       packet_wr;
  logic [7:0] tx_data;
  logic       tx_wr;
  logic       tx_done;
  logic       tx_busy;

  int n_chk  = 0;
  int n_fail = 0;
  int vcnt   = 0;
  int ecnt   = 0;
  int v0, e0, w0;
  logic [7:0] txq[$];
  logic [7:0] exp6 [6];
  logic [7:0] exp3 [3];

  always #5 clk = ~clk;

  s3g_link dut (
    .clk             (clk),
    .rst             (rst),
    .rx_data         (rx_data),
    .rx_done         (rx_done),
    .rx_packet_valid (rx_packet_valid),
    .rx_crc_error    (rx_crc_error),
    .rx_len          (rx_len),
    .rx_buf0         (rx_buf0),
    .rx_buf1         (rx_buf1),
    .rx_buf2         (rx_buf2),
    .rx_buf3         (rx_buf3),
    .payload_len     (payload_len),
    .buf0            (buf0),
    .buf1            (buf1),
    .buf2            (buf2),
    .buf3            (buf3),
    .packet_wr       (packet_wr),
    .tx_data         (tx_data),
    .tx_wr           (tx_wr),
    .tx_done         (tx_done),
    .tx_busy         (tx_busy)
  );

  always @(negedge clk) begin
    if (rx_packet_valid) vcnt++;
    if (rx_crc_error) ecnt++;
    if (tx_wr) txq.push_back(tx_data);
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp_v);
    n_chk++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  task automatic rx_byte(input logic [7:0] b);
    @(negedge clk);
    rx_data = b;
    rx_done = 1'b1;
    @(negedge clk);
    rx_done = 1'b0;
  endtask

  task automatic wr_pkt();
    @(negedge clk);
    packet_wr = 1'b1;
    @(negedge clk);
    packet_wr = 1'b0;
  endtask

  task automatic ack(input int gap);
    repeat (gap) @(negedge clk);
    tx_done = 1'b1;
    @(negedge clk);
    tx_done = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    rx_data = 8'h00; rx_done = 1'b0;
    payload_len = 8'd0;
    buf0 = 8'h00; buf1 = 8'h00; buf2 = 8'h00; buf3 = 8'h00;
    packet_wr = 1'b0; tx_done = 1'b0;
    exp6 = '{8'hD5, 8'h03, 8'h01, 8'h02, 8'h03, 8'hD8};
    exp3 = '{8'hD5, 8'h00, 8'h00};
    idle(3);
    rst = 1'b0;
    idle(1);

    // reset state
    chk("rst_valid", 32'(rx_packet_valid), 0);
    chk("rst_err", 32'(rx_crc_error), 0);
    chk("rst_len", 32'(rx_len), 0);
    chk("rst_bufs", {rx_buf3, rx_buf2, rx_buf1, rx_buf0}, 0);
    chk("rst_tx", {22'd0, tx_data, tx_wr, tx_busy}, 0);

    // RX good packet after junk
    v0 = vcnt; e0 = ecnt;
    rx_byte(8'h0D);
    rx_byte(8'hD5); rx_byte(8'h03); rx_byte(8'h01);
    rx_byte(8'h02); rx_byte(8'h03); rx_byte(8'hD8);
    chk("good_pulse", 32'(rx_packet_valid), 1);
    idle(3);
    chk("good_vcnt", 32'(vcnt - v0), 1);
    chk("good_ecnt", 32'(ecnt - e0), 0);
    chk("good_len", 32'(rx_len), 3);
    chk("good_bufs", {rx_buf3, rx_buf2, rx_buf1, rx_buf0}, 32'h00030201);

    // RX bad CRC keeps previous capture
    v0 = vcnt; e0 = ecnt;
    rx_byte(8'hD5); rx_byte(8'h03); rx_byte(8'h01);
    rx_byte(8'h02); rx_byte(8'h03); rx_byte(8'hCC);
    chk("bad_pulse", 32'(rx_crc_error), 1);
    idle(3);
    chk("bad_vcnt", 32'(vcnt - v0), 0);
    chk("bad_ecnt", 32'(ecnt - e0), 1);
    chk("bad_len", 32'(rx_len), 3);
    chk("bad_bufs", {rx_buf3, rx_buf2, rx_buf1, rx_buf0}, 32'h00030201);

    // zero-length packet
    v0 = vcnt;
    rx_byte(8'hD5); rx_byte(8'h00); rx_byte(8'h00);
    idle(2);
    chk("zero_vcnt", 32'(vcnt - v0), 1);
    chk("zero_len", 32'(rx_len), 0);
    chk("zero_bufs", {rx_buf3, rx_buf2, rx_buf1, rx_buf0}, 0);

    // 0xD5 as payload data, CRC(D5)=68
    v0 = vcnt;
    rx_byte(8'hD5); rx_byte(8'h01); rx_byte(8'hD5); rx_byte(8'h68);
    idle(2);
    chk("d5data_vcnt", 32'(vcnt - v0), 1);
    chk("d5data_len", 32'(rx_len), 1);
    chk("d5data_bufs", {rx_buf3, rx_buf2, rx_buf1, rx_buf0}, 32'h000000D5);

    // oversize length dropped, then good packet accepted
    v0 = vcnt; e0 = ecnt;
    rx_byte(8'hD5); rx_byte(8'h21);
    rx_byte(8'hD5); rx_byte(8'h03); rx_byte(8'h01);
    rx_byte(8'h02); rx_byte(8'h03); rx_byte(8'hD8);
    idle(2);
    chk("drop_vcnt", 32'(vcnt - v0), 1);
    chk("drop_ecnt", 32'(ecnt - e0), 0);
    chk("drop_len", 32'(rx_len), 3);

    // TX packet with handshake
    w0 = txq.size();
    payload_len = 8'd3; buf0 = 8'h01; buf1 = 8'h02; buf2 = 8'h03; buf3 = 8'hEE;
    wr_pkt();
    chk("tx_first_wr", 32'(tx_wr), 1);
    chk("tx_first_busy", 32'(tx_busy), 1);
    chk("tx_first_data", 32'(tx_data), 32'hD5);
    idle(20);
    chk("tx_noack_cnt", 32'(txq.size() - w0), 1);
    payload_len = 8'd1; buf0 = 8'h77;
    wr_pkt();
    for (int i = 0; i < 6; i++) begin
      if (i == 5) chk("tx_busy_pre", 32'(tx_busy), 1);
      ack(10);
      if (i < 5) begin
        chk($sformatf("tx_wr_%0d", i + 1), 32'(tx_wr), 1);
        chk($sformatf("tx_data_%0d", i + 1), 32'(tx_data), 32'(exp6[i+1]));
      end else begin
        chk("tx_busy_post", 32'(tx_busy), 0);
      end
    end
    idle(3);
    chk("tx_cnt", 32'(txq.size() - w0), 6);
    for (int i = 0; i < 6; i++) begin
      if (w0 + i < txq.size())
        chk($sformatf("tx_seq_%0d", i), 32'(txq[w0+i]), 32'(exp6[i]));
    end

    // spurious tx_done in idle
    w0 = txq.size();
    ack(2);
    idle(5);
    chk("spur_cnt", 32'(txq.size() - w0), 0);
    chk("spur_busy", 32'(tx_busy), 0);

    // reset mid-RX payload and mid-TX
    rx_byte(8'hD5); rx_byte(8'h03); rx_byte(8'h01);
    payload_len = 8'd2; buf0 = 8'h0A; buf1 = 8'h0B;
    wr_pkt();
    ack(3);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("mid_rst_rx", {rx_len, rx_buf3, rx_buf2, rx_buf1}, 0);
    chk("mid_rst_rx0", {22'd0, rx_buf0, rx_packet_valid, rx_crc_error}, 0);
    chk("mid_rst_tx", {22'd0, tx_data, tx_wr, tx_busy}, 0);
    idle(2);
    rst = 1'b0;
    idle(1);
    v0 = vcnt; e0 = ecnt;
    rx_byte(8'hD5); rx_byte(8'h03); rx_byte(8'h01);
    rx_byte(8'h02); rx_byte(8'h03); rx_byte(8'hD8);
    idle(2);
    chk("post_rx_vcnt", 32'(vcnt - v0), 1);
    chk("post_rx_ecnt", 32'(ecnt - e0), 0);
    chk("post_rx_bufs", {rx_buf3, rx_buf2, rx_buf1, rx_buf0}, 32'h00030201);
    w0 = txq.size();
    payload_len = 8'd0;
    wr_pkt();
    ack(4); ack(4); ack(4);
    idle(3);
    chk("post_tx_busy", 32'(tx_busy), 0);
    chk("post_tx_cnt", 32'(txq.size() - w0), 3);
    for (int i = 0; i < 3; i++) begin
      if (w0 + i < txq.size())
        chk($sformatf("post_tx_seq_%0d", i), 32'(txq[w0+i]), 32'(exp3[i]));
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
